// File: rtl/exception_ctrl.sv
// MEM-stage exception controller: picks the highest-priority exception, waits out stalls,
// reports it to CP0 for exactly one cycle and then holds the pipeline flush for a drain window.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        ov_i,
  input  logic        adel_ld_i,
  input  logic        ades_i,
  input  logic        eret_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] mem_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        stall_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic [31:0] bad_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_COMMIT = 2'd2,
    S_DRAIN  = 2'd3
  } state_e;

  localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES);
  localparam logic [31:0] CODE_ERET  = 32'h0000_000e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic [31:0] exc_q;
  logic [31:0] cia_q;
  logic [31:0] bad_q;
  logic        ds_q;
  logic        flush_q;
  logic [31:0] newpc_q;
  logic        busy_q;

  logic        int_pend_s;
  logic        event_s;
  logic [31:0] code_s;
  logic [31:0] bad_s;
  logic        unused_s;

  assign int_pend_s = (|(cause_i[15:8] & status_i[15:8])) & status_i[0] & ~status_i[1];
  assign unused_s   = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};
  assign event_s    = inst_valid_i & (code_s != 32'h0);
  assign cnt_d      = cnt_q - 4'd1;

  // Priority encoder over the exception sources, with the matching bad address.
  always_comb begin
    code_s = 32'h0;
    bad_s  = 32'h0;
    if (int_pend_s) begin
      code_s = 32'h0000_0001;
    end else if (adel_if_i) begin
      code_s = 32'h0000_0004;
      bad_s  = pc_i;
    end else if (ri_i) begin
      code_s = 32'h0000_000a;
    end else if (syscall_i) begin
      code_s = 32'h0000_0008;
    end else if (break_i) begin
      code_s = 32'h0000_0009;
    end else if (ov_i) begin
      code_s = 32'h0000_000c;
    end else if (adel_ld_i) begin
      code_s = 32'h0000_0004;
      bad_s  = mem_addr_i;
    end else if (ades_i) begin
      code_s = 32'h0000_0005;
      bad_s  = mem_addr_i;
    end else if (eret_i) begin
      code_s = CODE_ERET;
    end else begin
      code_s = 32'h0;
      bad_s  = 32'h0;
    end
  end

  // Sequencer; every output is a register so CP0 sees a clean one-cycle code pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      exc_q   <= 32'h0;
      cia_q   <= 32'h0;
      bad_q   <= 32'h0;
      ds_q    <= 1'b0;
      flush_q <= 1'b0;
      newpc_q <= 32'h0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_WAIT: begin
          if (!event_s) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (stall_i) begin
            state_q <= S_WAIT;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_COMMIT;
            exc_q   <= code_s;
            cia_q   <= pc_i;
            bad_q   <= bad_s;
            ds_q    <= is_in_delayslot_i;
            flush_q <= 1'b1;
            newpc_q <= (code_s == CODE_ERET) ? epc_i : EXC_VECTOR;
            busy_q  <= 1'b1;
          end
        end
        S_COMMIT: begin
          state_q <= S_DRAIN;
          cnt_q   <= DRAIN_LOAD;
          exc_q   <= 32'h0;
        end
        S_DRAIN: begin
          // A zero count is treated like one so a corrupted counter cannot wrap.
          if (cnt_d == 4'd0 || cnt_q == 4'd0) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            flush_q <= 1'b0;
            newpc_q <= 32'h0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 4'd0;
          exc_q   <= 32'h0;
          flush_q <= 1'b0;
          newpc_q <= 32'h0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign excepttype_o        = exc_q;
  assign current_inst_addr_o = cia_q;
  assign bad_addr_o          = bad_q;
  assign is_in_delayslot_o   = ds_q;
  assign flush_o             = flush_q;
  assign newpc_o             = newpc_q;
  assign busy_o              = busy_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed-vector bench for exception_ctrl: inputs change on the falling edge,
// outputs are checked on the following falling edge against hand-computed values.
module tb_exception_ctrl;

  logic        clk;
  logic        rst;
  logic        inst_valid_i;
  logic        adel_if_i, ri_i, syscall_i, break_i, ov_i, adel_ld_i, ades_i, eret_i;
  logic [31:0] pc_i, mem_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] status_i, cause_i, epc_i;
  logic        stall_i;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, newpc_o;
  logic        is_in_delayslot_o, flush_o, busy_o;

  int n_vec = 0;
  int n_err = 0;

  exception_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .inst_valid_i        (inst_valid_i),
    .adel_if_i           (adel_if_i),
    .ri_i                (ri_i),
    .syscall_i           (syscall_i),
    .break_i             (break_i),
    .ov_i                (ov_i),
    .adel_ld_i           (adel_ld_i),
    .ades_i              (ades_i),
    .eret_i              (eret_i),
    .pc_i                (pc_i),
    .mem_addr_i          (mem_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .status_i            (status_i),
    .cause_i             (cause_i),
    .epc_i               (epc_i),
    .stall_i             (stall_i),
    .excepttype_o        (excepttype_o),
    .current_inst_addr_o (current_inst_addr_o),
    .bad_addr_o          (bad_addr_o),
    .is_in_delayslot_o   (is_in_delayslot_o),
    .flush_o             (flush_o),
    .newpc_o             (newpc_o),
    .busy_o              (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clr_in();
    inst_valid_i = 1'b0;
    adel_if_i = 1'b0; ri_i = 1'b0; syscall_i = 1'b0; break_i = 1'b0;
    ov_i = 1'b0; adel_ld_i = 1'b0; ades_i = 1'b0; eret_i = 1'b0;
    pc_i = 32'h0; mem_addr_i = 32'h0; is_in_delayslot_i = 1'b0;
    status_i = 32'h0; cause_i = 32'h0; epc_i = 32'h0; stall_i = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},  {31'h0, busy_o},  32'h0);
    check({tag, ".flush"}, {31'h0, flush_o}, 32'h0);
    check({tag, ".exc"},   excepttype_o,     32'h0);
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    #1;
    check_idle("reset");
    check("reset.newpc", newpc_o, 32'h0);
    step();
    rst = 1'b0;

    // syscall, no stall: one COMMIT cycle then two DRAIN cycles
    inst_valid_i = 1'b1; syscall_i = 1'b1; pc_i = 32'hBFC00100; is_in_delayslot_i = 1'b1;
    step();
    clr_in();
    check("sys.exc",   excepttype_o,        32'h8);
    check("sys.newpc", newpc_o,             32'hBFC00380);
    check("sys.cia",   current_inst_addr_o, 32'hBFC00100);
    check("sys.ds",    {31'h0, is_in_delayslot_o}, 32'h1);
    check("sys.bad",   bad_addr_o,          32'h0);
    check("sys.flush", {31'h0, flush_o},    32'h1);
    step();
    check("sys.d1.flush", {31'h0, flush_o}, 32'h1);
    check("sys.d1.exc",   excepttype_o,     32'h0);
    check("sys.d1.newpc", newpc_o,          32'hBFC00380);
    check("sys.d1.busy",  {31'h0, busy_o},  32'h1);
    step();
    check("sys.d2.flush", {31'h0, flush_o}, 32'h1);
    step();
    check_idle("sys.end");

    // ov beats ades; ov has no bad address
    inst_valid_i = 1'b1; ov_i = 1'b1; ades_i = 1'b1; mem_addr_i = 32'h1003; pc_i = 32'h8000_0040;
    step();
    clr_in();
    check("ov.exc", excepttype_o, 32'hc);
    check("ov.bad", bad_addr_o,   32'h0);
    step(); step(); step();
    check_idle("ov.end");

    // flags without a valid instruction are ignored, interrupt included
    status_i = 32'h0000_0401; cause_i = 32'h0000_0400; ri_i = 1'b1;
    step();
    check_idle("noval");

    // pending interrupt beats ri
    inst_valid_i = 1'b1;
    step();
    clr_in();
    check("int.exc", excepttype_o, 32'h1);
    step(); step(); step();

    // interrupt masked by EXL -> ri wins
    inst_valid_i = 1'b1; status_i = 32'h0000_0403; cause_i = 32'h0000_0400; ri_i = 1'b1;
    step();
    clr_in();
    check("ri.exc", excepttype_o, 32'ha);
    step(); step(); step();
    check_idle("ri.end");

    // adel_ld held across a 3-cycle stall
    inst_valid_i = 1'b1; adel_ld_i = 1'b1; mem_addr_i = 32'h0000_2001; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.busy", {31'h0, busy_o},  32'h1);
      check("stall.exc",  excepttype_o,     32'h0);
      check("stall.flush",{31'h0, flush_o}, 32'h0);
    end
    stall_i = 1'b0;
    step();
    clr_in();
    check("adel.exc",   excepttype_o,     32'h4);
    check("adel.bad",   bad_addr_o,       32'h0000_2001);
    check("adel.flush", {31'h0, flush_o}, 32'h1);
    step(); step(); step();
    check_idle("adel.end");

    // WAIT abandons the event when the instruction goes away
    inst_valid_i = 1'b1; break_i = 1'b1; stall_i = 1'b1;
    step();
    check("wait.busy", {31'h0, busy_o}, 32'h1);
    inst_valid_i = 1'b0;
    step();
    clr_in();
    check_idle("wait.drop");

    // eret returns to EPC; syscall raised during DRAIN is ignored
    inst_valid_i = 1'b1; eret_i = 1'b1; epc_i = 32'hBFC00200;
    step();
    clr_in();
    check("eret.exc",   excepttype_o, 32'he);
    check("eret.newpc", newpc_o,      32'hBFC00200);
    inst_valid_i = 1'b1; syscall_i = 1'b1;
    step();
    check("eret.d1.exc", excepttype_o, 32'h0);
    step();
    check("eret.d2.exc",   excepttype_o, 32'h0);
    check("eret.d2.newpc", newpc_o,      32'hBFC00200);
    clr_in();
    step();
    check_idle("eret.end");
    step();
    check_idle("eret.quiet");

    // asynchronous reset in the middle of DRAIN
    inst_valid_i = 1'b1; syscall_i = 1'b1; pc_i = 32'hBFC00300;
    step();
    clr_in();
    step();
    check("pre.flush", {31'h0, flush_o}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check_idle("arst");
    check("arst.cia", current_inst_addr_o, 32'h0);
    step();
    rst = 1'b0;
    step();
    check_idle("post.quiet");

    // first event straight after reset release
    rst = 1'b1;
    step();
    rst = 1'b0;
    inst_valid_i = 1'b1; break_i = 1'b1;
    step();
    clr_in();
    check("post.exc", excepttype_o, 32'h9);
    step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC00380, handler entry PC.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 2, flush-hold cycles after commit (range 1-15).
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports clk, rst.
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 inst_valid_i  in  1  MEM-stage holds a real instruction.
REQ-007 adel_if_i, ri_i, syscall_i, break_i, ov_i, adel_ld_i, ades_i, eret_i  in  1 each  MEM-stage exception flags.
REQ-008 pc_i  in  32  MEM-stage instruction address.
REQ-009 mem_addr_i  in  32  MEM-stage data address.
REQ-010 is_in_delayslot_i  in  1  MEM-stage instruction is a delay-slot instruction.
REQ-011 status_i, cause_i, epc_i  in  32 each  current CP0 Status/Cause/EPC.
REQ-012 stall_i  in  1  pipeline stall in effect.
REQ-013 excepttype_o  out  32  exception code to CP0.
REQ-014 current_inst_addr_o, bad_addr_o  out  32 each  to CP0.
REQ-015 is_in_delayslot_o  out  1  to CP0.
REQ-016 flush_o  out  1  flush all pipeline stages.
REQ-017 newpc_o  out  32  redirect PC, valid while flush_o=1.
REQ-018 busy_o  out  1  state is not IDLE.

Function
REQ-019 int_pend SHALL = |(cause_i[15:8] & status_i[15:8]) & status_i[0] & ~status_i[1].
REQ-020 SHALL detect an event only when inst_valid_i=1 and state=IDLE or WAIT; the highest-priority source SHALL be selected.
REQ-021 Priority, highest first: int_pend 0x1; adel_if 0x4 (bad=pc_i); ri 0xa; syscall 0x8; break 0x9; ov 0xc; adel_ld 0x4 (bad=mem_addr_i); ades 0x5 (bad=mem_addr_i); eret 0xe.
REQ-022 FSM states SHALL be IDLE, WAIT, COMMIT and DRAIN.
REQ-023 IDLE->COMMIT on detected event with stall_i=0, capturing code, pc_i, is_in_delayslot_i, bad address, epc_i.
REQ-024 IDLE->WAIT on detected event with stall_i=1.
REQ-025 WAIT SHALL re-evaluate detection every cycle and capture on the first stall_i=0 cycle, then go to COMMIT.
REQ-026 WAIT->IDLE if inst_valid_i falls or no event remains.
REQ-027 COMMIT SHALL last exactly one cycle regardless of stall_i.
REQ-028 In COMMIT: excepttype_o=captured code; flush_o=1; newpc_o=captured epc for 0xe, else EXC_VECTOR.
REQ-029 In COMMIT: current_inst_addr_o, is_in_delayslot_o and bad_addr_o SHALL equal captured values; bad_addr_o=0 for codes without a bad address.
REQ-030 COMMIT->DRAIN; a DRAIN_CYCLES down-counter SHALL be loaded.
REQ-031 In DRAIN: flush_o=1, newpc_o held, excepttype_o=0, all exception inputs ignored; DRAIN->IDLE when counter reaches 0.
REQ-032 excepttype_o SHALL be nonzero only in COMMIT, so CP0 updates once per event.
REQ-033 Latency: event sampled at edge N (stall_i=0) -> COMMIT during cycle N+1 -> IDLE after N+1+DRAIN_CYCLES.
REQ-034 Flags with inst_valid_i=0 SHALL be ignored, including int_pend.

Reset
REQ-035 rst=1 SHALL immediately (asynchronously) force IDLE, counter 0, all captured registers 0.
REQ-036 During reset all outputs SHALL be 0, including mid-WAIT, mid-COMMIT or mid-DRAIN.
REQ-037 After rst release, the first event SHALL be accepted on the next edge.

Verification
REQ-038 syscall_i=1, pc_i=0xBFC00100, stall_i=0 -> next cycle: excepttype_o=0x8, newpc_o=0xBFC00380, current_inst_addr_o=0xBFC00100, flush_o high 3 cycles total.
REQ-039 ov_i=1 and ades_i=1 together, mem_addr_i=0x1003 -> code 0xc, bad_addr_o=0.
REQ-040 Status=0x0000_0401, Cause[10]=1, ri_i=1 -> code 0x1; repeat with Status[1]=1 -> code 0xa.
REQ-041 adel_ld_i=1, stall_i=1 for 3 cycles -> busy_o=1 and excepttype_o=0 during the stall; COMMIT with code 0x4 and bad_addr_o=mem_addr_i one cycle after stall_i falls.
REQ-042 eret_i=1, epc_i=0xBFC00200 -> code 0xe, newpc_o=0xBFC00200; syscall_i asserted during DRAIN -> ignored.
REQ-043 rst asserted mid-DRAIN -> flush_o=0 and busy_o=0 within the same cycle; no residual event after release.
